dcsk_rx_bit_packer: RTL

// - Downstream stage of the DCSK receiver control FSM: owns the ones/zeros correlation counters and the output word path.
// - Consumes the FSM strobes (count inc/clr, out-reg load) and makes a majority decision per symbol.
// - Packs decided bits into WORD_W-bit words and buffers them in a small FIFO.
// - Presents words to the consumer over a valid/ready handshake.

---
 rtl/dcsk_rx_pkg.sv | 9 +
 rtl/dcsk_sync_fifo.sv | 59 +++++
 rtl/dcsk_rx_bit_packer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dcsk_rx_pkg.sv
// Shared DCSK receiver sizing; the control FSM imports the same values so the
// spread-factor counter width agrees across both stages.
package dcsk_rx_pkg;

  localparam int unsigned CNT_W_DEF      = 6;
  localparam int unsigned WORD_W_DEF     = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/dcsk_sync_fifo.sv
// Register-array synchronous FIFO with registered pointers and occupancy count.
// Push is accepted when full only if a pop happens in the same cycle.
module dcsk_sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dcsk_rx_bit_packer.sv
// DCSK receiver back end: ones/zeros correlation counters, per-symbol majority
// decision, MSB-first bit packing and a buffered valid/ready word output.
module dcsk_rx_bit_packer
  import dcsk_rx_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned WORD_W     = WORD_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Ones_Count_Inc,
  input  logic              Zeros_Count_Inc,
  input  logic              Ones_Zeros_Count_Clr,
  input  logic              STP_Out_Reg_Load,
  input  logic              Frame_Abort,
  input  logic              Word_Ready,
  output logic [WORD_W-1:0] Word_Out,
  output logic              Word_Valid,
  output logic              Bit_Decided,
  output logic              Bit_Value,
  output logic              Tie_Flag,
  output logic              Overflow
);

  localparam int unsigned        IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  logic [CNT_W-1:0]  r_ones;
  logic [CNT_W-1:0]  r_zeros;
  logic [WORD_W-2:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic              r_bit_decided;
  logic              r_bit_value;
  logic              r_tie;
  logic              r_overflow;

  logic              w_load;
  logic              w_bit;
  logic              w_tie;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_fifo_data;

  // Decision uses the counters as they stand before this cycle's clear/inc.
  assign w_load = STP_Out_Reg_Load && !Frame_Abort;
  assign w_bit  = (r_ones >= r_zeros);
  assign w_tie  = (r_ones == r_zeros);
  assign w_word = {r_shift, w_bit};
  assign w_push = w_load && (r_idx == LAST_IDX);
  assign w_pop  = Word_Ready && !w_empty;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ones  <= '0;
      r_zeros <= '0;
    end else if (Frame_Abort || Ones_Zeros_Count_Clr) begin
      r_ones  <= '0;
      r_zeros <= '0;
    end else begin
      if (Ones_Count_Inc && (r_ones != CNT_MAX)) begin
        r_ones <= r_ones + CNT_W'(1);
      end
      if (Zeros_Count_Inc && (r_zeros != CNT_MAX)) begin
        r_zeros <= r_zeros + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (Frame_Abort) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (w_load) begin
      if (r_idx == LAST_IDX) begin
        r_shift <= '0;
        r_idx   <= '0;
      end else begin
        r_shift <= w_word[WORD_W-2:0];
        r_idx   <= r_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_bit_decided <= 1'b0;
      r_bit_value   <= 1'b0;
      r_tie         <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_bit_decided <= w_load;
      r_tie         <= w_load && w_tie;
      if (w_load) begin
        r_bit_value <= w_bit;
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  dcsk_sync_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_word),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign Word_Out    = w_fifo_data;
  assign Word_Valid  = !w_empty;
  assign Bit_Decided = r_bit_decided;
  assign Bit_Value   = r_bit_value;
  assign Tie_Flag    = r_tie;
  assign Overflow    = r_overflow;

endmodule
